// File: rtl/uart_pkg.sv
// Shared UART definitions used by uart_send and uart_recv.
// UART_SEND_PARITY_EN adds the PARITY state to the transmit state enum.
package uart_pkg;

    localparam int CLKS_PER_BIT_DEFAULT = 10416;
    localparam int DATA_BITS            = 8;

`ifdef UART_SEND_PARITY_EN
    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_STOP   = 3'd3,
        TX_PARITY = 3'd4
    } tx_state_t;
`else
    typedef enum logic [2:0] {
        TX_IDLE  = 3'd0,
        TX_START = 3'd1,
        TX_DATA  = 3'd2,
        TX_STOP  = 3'd3
    } tx_state_t;
`endif

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// Holding clear keeps the count at 0, so every frame starts on a fresh bit boundary.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_tick;

    assign w_tick = (r_cnt == LAST);
    assign tick   = w_tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clear || w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_send.sv
// UART transmitter, 8N1 (8E1 when UART_SEND_PARITY_EN is defined); tx is registered.
// States: IDLE waits for send, START/DATA/PARITY/STOP each hold tx for one bit period.
module uart_send
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       send,
    output logic       ready,
    output logic       tx
);

    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

    tx_state_t        r_state;
    tx_state_t        w_state_next;
    logic [7:0]       r_shift;
    logic [7:0]       w_shift_next;
    logic [BIT_W-1:0] r_bit_cnt;
    logic [BIT_W-1:0] w_bit_next;
    logic             r_tx;
    logic             w_tx_next;
    logic             w_clear;
    logic             w_tick;

`ifdef UART_SEND_PARITY_EN
    logic             r_parity;
    logic             w_parity_next;
`endif

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clear(w_clear),
        .tick (w_tick)
    );

    assign ready = (r_state == TX_IDLE);
    assign tx    = r_tx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= TX_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_tx      <= 1'b1;
`ifdef UART_SEND_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_next;
            r_shift   <= w_shift_next;
            r_bit_cnt <= w_bit_next;
            r_tx      <= w_tx_next;
`ifdef UART_SEND_PARITY_EN
            r_parity  <= w_parity_next;
`endif
        end
    end

    // tx is the registered form of the next-state output, so the line never glitches
    always_comb begin
        w_state_next = r_state;
        w_shift_next = r_shift;
        w_bit_next   = r_bit_cnt;
        w_tx_next    = r_tx;
        w_clear      = 1'b0;
`ifdef UART_SEND_PARITY_EN
        w_parity_next = r_parity;
`endif
        case (r_state)
            TX_IDLE: begin
                w_clear   = 1'b1;
                w_tx_next = 1'b1;
                if (send) begin
                    w_state_next = TX_START;
                    w_shift_next = data;
                    w_bit_next   = '0;
                    w_tx_next    = 1'b0;
`ifdef UART_SEND_PARITY_EN
                    w_parity_next = ^data;
`endif
                end
            end
            TX_START: begin
                if (w_tick) begin
                    w_state_next = TX_DATA;
                    w_tx_next    = r_shift[0];
                end
            end
            TX_DATA: begin
                if (w_tick) begin
                    if (r_bit_cnt == LAST_BIT) begin
`ifdef UART_SEND_PARITY_EN
                        w_state_next = TX_PARITY;
                        w_tx_next    = r_parity;
`else
                        w_state_next = TX_STOP;
                        w_tx_next    = 1'b1;
`endif
                    end else begin
                        w_shift_next = r_shift >> 1;
                        w_bit_next   = r_bit_cnt + 1'b1;
                        w_tx_next    = r_shift[1];
                    end
                end
            end
`ifdef UART_SEND_PARITY_EN
            TX_PARITY: begin
                if (w_tick) begin
                    w_state_next = TX_STOP;
                    w_tx_next    = 1'b1;
                end
            end
`endif
            TX_STOP: begin
                if (w_tick) begin
                    w_state_next = TX_IDLE;
                    w_tx_next    = 1'b1;
                end
            end
            default: begin
                w_state_next = TX_IDLE;
                w_tx_next    = 1'b1;
                w_clear      = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_send.sv
// Directed bench for uart_send at CLKS_PER_BIT=4; parity cases run when UART_SEND_PARITY_EN is defined.
module tb_uart_send;

    localparam int CPB = 4;
`ifdef UART_SEND_PARITY_EN
    localparam int FRAME = 11 * CPB;
`else
    localparam int FRAME = 10 * CPB;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data;
    logic       send;
    logic       ready;
    logic       tx;

    int   total = 0;
    int   bad   = 0;
    logic par_seen;

    uart_send #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .data (data),
        .send (send),
        .ready(ready),
        .tx   (tx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Expected line level per bit slot, LSB first: start, d[0..7], [parity], stop.
    function automatic logic [10:0] mk_frame(input logic [7:0] d);
        logic [10:0] f;
        f = 11'h7FF;
        f[0]   = 1'b0;
        f[8:1] = d;
`ifdef UART_SEND_PARITY_EN
        f[9]   = ^d;
`endif
        return f;
    endfunction

    // Called at the negedge of frame cycle 0; returns at the negedge of cycle n.
    task automatic run_frame(input string tag, input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            chk({tag, "_tx"}, tx, f[i / CPB]);
            chk({tag, "_ready"}, ready, 1'b0);
            if (i == 9 * CPB) par_seen = tx;
            @(negedge clk);
        end
    endtask

    task automatic idle_check(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            chk({tag, "_tx"}, tx, 1'b1);
            chk({tag, "_ready"}, ready, 1'b1);
            @(negedge clk);
        end
    endtask

    task automatic accept(input logic [7:0] d, input logic hold);
        data = d;
        send = 1'b1;
        @(negedge clk);
        if (!hold) send = 1'b0;
    endtask

    initial begin
        rst  = 1'b1;
        send = 1'b0;
        data = 8'h00;
        par_seen = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1'b1);
        chk("rst_ready", ready, 1'b1);
        rst = 1'b0;
        idle_check("idle", 20);

        accept(8'hA5, 1'b0);
        run_frame("a5", mk_frame(8'hA5), FRAME);
        chk("a5_end_ready", ready, 1'b1);
        chk("a5_end_tx", tx, 1'b1);
        idle_check("post_a5", 3);

        // held send: data changes mid-frame must not disturb the first byte
        accept(8'h00, 1'b1);
        data = 8'hFF;
        run_frame("b2b0", mk_frame(8'h00), FRAME);
        chk("gap_ready", ready, 1'b1);
        chk("gap_tx", tx, 1'b1);
        @(negedge clk);
        send = 1'b0;
        data = 8'h12;
        run_frame("b2b1", mk_frame(8'hFF), FRAME);
        idle_check("post_b2b", 3);

        accept(8'h0F, 1'b0);
        run_frame("abort", mk_frame(8'h0F), 13);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_tx", tx, 1'b1);
        chk("abort_ready", ready, 1'b1);
        rst = 1'b0;
        idle_check("post_abort", 4);
        accept(8'h3C, 1'b0);
        run_frame("3c", mk_frame(8'h3C), FRAME);
        idle_check("post_3c", 2);

        // reset wins over a simultaneous send
        rst  = 1'b1;
        send = 1'b1;
        data = 8'hAA;
        @(negedge clk);
        chk("rs_tx", tx, 1'b1);
        chk("rs_ready", ready, 1'b1);
        rst  = 1'b0;
        send = 1'b0;
        idle_check("post_rs", 6);

`ifdef UART_SEND_PARITY_EN
        accept(8'h07, 1'b0);
        run_frame("p07", mk_frame(8'h07), FRAME);
        chk("p07_parity", par_seen, 1'b1);
        chk("p07_end_ready", ready, 1'b1);
        accept(8'h03, 1'b0);
        run_frame("p03", mk_frame(8'h03), FRAME);
        chk("p03_parity", par_seen, 1'b0);
        chk("p03_end_ready", ready, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
